// File: rtl/cprv_pkg.sv
// cprv_pkg: shared types for the unified memory arbiter.
// Sequencer states and transaction owner encoding.
package cprv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DELIVER
   } arb_state_t;

   typedef enum logic {
      OWNER_IF,
      OWNER_MEM
   } arb_owner_t;

endpackage

// File: rtl/cprv_arb_grant.sv
// cprv_arb_grant: picks IF or MEM when both request in IDLE.
// CPRV_ARB_RR_EN selects round-robin, else MEM has fixed priority.
module cprv_arb_grant
   import cprv_pkg::*;
(
   input  logic       valid_if,
   input  logic       valid_mem,
`ifdef CPRV_ARB_RR_EN
   input  arb_owner_t last_owner,
`endif
   output logic       grant_if,
   output logic       grant_mem
);

   // grant decision, a lone requester always wins
   always_comb begin
      grant_if  = 1'b0;
      grant_mem = 1'b0;
`ifdef CPRV_ARB_RR_EN
      if (valid_if && valid_mem) begin
         grant_mem = (last_owner == OWNER_IF);
         grant_if  = (last_owner == OWNER_MEM);
      end else begin
         grant_if  = valid_if;
         grant_mem = valid_mem;
      end
`else
      grant_mem = valid_mem;
      grant_if  = valid_if & ~valid_mem;
`endif
   end

endmodule

// File: rtl/cprv_mem_arbiter.sv
// cprv_mem_arbiter: shares one memory port between IF and MEM.
// One transaction in flight; CPRV_ARB_RR_EN enables round-robin grant.
module cprv_mem_arbiter
   import cprv_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_imem_i,
   output logic                  ready_imem_o,
   input  logic [DATA_WIDTH-1:0] instr_addr_imem_i,
   output logic                  valid_if_o,
   input  logic                  ready_if_i,
   output logic [DATA_WIDTH-1:0] instr_data_if_o,
   input  logic                  valid_dmem_i,
   output logic                  ready_dmem_o,
   input  logic [DATA_WIDTH-1:0] addr_dmem_i,
   input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
   input  logic                  w_en_dmem_i,
   output logic                  valid_mem_dmem_o,
   input  logic                  ready_mem_dmem_i,
   output logic [DATA_WIDTH-1:0] rdata_dmem_o,
   output logic                  valid_bus_o,
   input  logic                  ready_bus_i,
   output logic [DATA_WIDTH-1:0] addr_bus_o,
   output logic [DATA_WIDTH-1:0] wdata_bus_o,
   output logic                  w_en_bus_o,
   input  logic                  valid_bus_i,
   output logic                  ready_bus_o,
   input  logic [DATA_WIDTH-1:0] rdata_bus_i
);

   arb_state_t            state_q;
   arb_state_t            state_n;
   arb_owner_t            owner_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  grant_if;
   logic                  grant_mem;
   logic                  idle;
   logic                  hs_if;
   logic                  hs_mem;
   logic                  owner_rdy;

`ifdef CPRV_ARB_RR_EN
   arb_owner_t            last_q;

   // remember who won the last IDLE handshake; reset favours IF
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= OWNER_MEM;
      end else if (hs_mem) begin
         last_q <= OWNER_MEM;
      end else if (hs_if) begin
         last_q <= OWNER_IF;
      end
   end
`endif

   cprv_arb_grant u_grant (
      .valid_if   (valid_imem_i),
      .valid_mem  (valid_dmem_i),
`ifdef CPRV_ARB_RR_EN
      .last_owner (last_q),
`endif
      .grant_if   (grant_if),
      .grant_mem  (grant_mem)
   );

   assign idle      = (state_q == IDLE);
   assign hs_if     = idle & grant_if & valid_imem_i;
   assign hs_mem    = idle & grant_mem & valid_dmem_i;
   assign owner_rdy = (owner_q == OWNER_MEM) ? ready_mem_dmem_i
                                             : ready_if_i;

   // sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // next-state: one transaction walks IDLE->REQ->RESP->DELIVER
   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE:    if (hs_if || hs_mem) state_n = REQ;
         REQ:     if (ready_bus_i)     state_n = RESP;
         RESP:    if (valid_bus_i)     state_n = DELIVER;
         DELIVER: if (owner_rdy)       state_n = IDLE;
         default:                      state_n = IDLE;
      endcase
   end

   // request payload, owner and response data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWNER_IF;
         addr_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         if (hs_mem) begin
            owner_q <= OWNER_MEM;
            addr_q  <= addr_dmem_i;
            wdata_q <= wdata_dmem_i;
            wen_q   <= w_en_dmem_i;
         end else if (hs_if) begin
            owner_q <= OWNER_IF;
            addr_q  <= instr_addr_imem_i;
            wdata_q <= '0;
            wen_q   <= 1'b0;
         end
         if (state_q == RESP && valid_bus_i) begin
            data_q <= rdata_bus_i;
         end
      end
   end

   // handshake outputs decoded from state, only valids are steered
   always_comb begin
      ready_imem_o     = hs_if & ~rst;
      ready_dmem_o     = hs_mem & ~rst;
      valid_bus_o      = (state_q == REQ);
      ready_bus_o      = (state_q == RESP);
      valid_if_o       = (state_q == DELIVER) & (owner_q == OWNER_IF);
      valid_mem_dmem_o = (state_q == DELIVER) & (owner_q == OWNER_MEM);
      addr_bus_o       = addr_q;
      wdata_bus_o      = wdata_q;
      w_en_bus_o       = wen_q;
      instr_data_if_o  = data_q;
      rdata_dmem_o     = data_q;
   end

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// tb_cprv_mem_arbiter: directed checks of the memory arbiter.
// Expectations are hand-computed; RR build uses a last-owner model.
module tb_cprv_mem_arbiter;

`ifdef CPRV_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        valid_imem_i;
   logic        ready_imem_o;
   logic [63:0] instr_addr_imem_i;
   logic        valid_if_o;
   logic        ready_if_i;
   logic [63:0] instr_data_if_o;
   logic        valid_dmem_i;
   logic        ready_dmem_o;
   logic [63:0] addr_dmem_i;
   logic [63:0] wdata_dmem_i;
   logic        w_en_dmem_i;
   logic        valid_mem_dmem_o;
   logic        ready_mem_dmem_i;
   logic [63:0] rdata_dmem_o;
   logic        valid_bus_o;
   logic        ready_bus_i;
   logic [63:0] addr_bus_o;
   logic [63:0] wdata_bus_o;
   logic        w_en_bus_o;
   logic        valid_bus_i;
   logic        ready_bus_o;
   logic [63:0] rdata_bus_i;

   int total = 0;
   int bad   = 0;
   bit last_mem = 1'b1;

   cprv_mem_arbiter #(.DATA_WIDTH(64)) dut (
      .clk               (clk),
      .rst               (rst),
      .valid_imem_i      (valid_imem_i),
      .ready_imem_o      (ready_imem_o),
      .instr_addr_imem_i (instr_addr_imem_i),
      .valid_if_o        (valid_if_o),
      .ready_if_i        (ready_if_i),
      .instr_data_if_o   (instr_data_if_o),
      .valid_dmem_i      (valid_dmem_i),
      .ready_dmem_o      (ready_dmem_o),
      .addr_dmem_i       (addr_dmem_i),
      .wdata_dmem_i      (wdata_dmem_i),
      .w_en_dmem_i       (w_en_dmem_i),
      .valid_mem_dmem_o  (valid_mem_dmem_o),
      .ready_mem_dmem_i  (ready_mem_dmem_i),
      .rdata_dmem_o      (rdata_dmem_o),
      .valid_bus_o       (valid_bus_o),
      .ready_bus_i       (ready_bus_i),
      .addr_bus_o        (addr_bus_o),
      .wdata_bus_o       (wdata_bus_o),
      .w_en_bus_o        (w_en_bus_o),
      .valid_bus_i       (valid_bus_i),
      .ready_bus_o       (ready_bus_o),
      .rdata_bus_i       (rdata_bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic got,
                       input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // one full transaction from the IDLE grant cycle to return to IDLE
   task automatic do_txn(input string tag, input logic exp_mem,
                         input logic [63:0] exp_addr,
                         input logic [63:0] exp_wdata,
                         input logic exp_wen,
                         input logic [63:0] rdata);
      #1;
      chkb({tag, ".rdy_mem"}, ready_dmem_o, exp_mem);
      chkb({tag, ".rdy_if"}, ready_imem_o, ~exp_mem);
      tick();
      chkb({tag, ".bus_v"}, valid_bus_o, 1'b1);
      chk({tag, ".bus_a"}, addr_bus_o, exp_addr);
      chk({tag, ".bus_wd"}, wdata_bus_o, exp_wdata);
      chkb({tag, ".bus_we"}, w_en_bus_o, exp_wen);
      chkb({tag, ".rdy_if_busy"}, ready_imem_o, 1'b0);
      tick();
      chkb({tag, ".bus_rr"}, ready_bus_o, 1'b1);
      chkb({tag, ".bus_v0"}, valid_bus_o, 1'b0);
      valid_bus_i = 1'b1;
      rdata_bus_i = rdata;
      tick();
      valid_bus_i = 1'b0;
      chkb({tag, ".v_if"}, valid_if_o, ~exp_mem);
      chkb({tag, ".v_mem"}, valid_mem_dmem_o, exp_mem);
      chk({tag, ".d_if"}, instr_data_if_o, rdata);
      chk({tag, ".d_mem"}, rdata_dmem_o, rdata);
      tick();
      chkb({tag, ".end_if"}, valid_if_o, 1'b0);
      chkb({tag, ".end_mem"}, valid_mem_dmem_o, 1'b0);
      last_mem = exp_mem;
   endtask

   initial begin
      rst               = 1'b1;
      valid_imem_i      = 1'b1;
      instr_addr_imem_i = 64'h0;
      ready_if_i        = 1'b1;
      valid_dmem_i      = 1'b0;
      addr_dmem_i       = 64'h0;
      wdata_dmem_i      = 64'h0;
      w_en_dmem_i       = 1'b0;
      ready_mem_dmem_i  = 1'b1;
      ready_bus_i       = 1'b1;
      valid_bus_i       = 1'b0;
      rdata_bus_i       = 64'h0;

      // reset state
      #3;
      chkb("rst.rdy_if", ready_imem_o, 1'b0);
      chkb("rst.bus_v", valid_bus_o, 1'b0);
      chkb("rst.bus_r", ready_bus_o, 1'b0);
      chkb("rst.v_if", valid_if_o, 1'b0);
      chkb("rst.v_mem", valid_mem_dmem_o, 1'b0);
      chk("rst.addr", addr_bus_o, 64'h0);
      chk("rst.data", instr_data_if_o, 64'h0);
      valid_imem_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // fetch only, minimum latency
      valid_imem_i      = 1'b1;
      instr_addr_imem_i = 64'h1000;
      do_txn("fetch", 1'b0, 64'h1000, 64'h0, 1'b0, 64'h13);
      valid_imem_i = 1'b0;
      tick();

      // store with 3-cycle bus stall; stray bus response ignored
      valid_dmem_i = 1'b1;
      addr_dmem_i  = 64'h2000;
      wdata_dmem_i = 64'hDEADBEEF;
      w_en_dmem_i  = 1'b1;
      ready_bus_i  = 1'b0;
      #1;
      chkb("st.rdy", ready_dmem_o, 1'b1);
      tick();
      valid_dmem_i = 1'b0;
      w_en_dmem_i  = 1'b0;
      wdata_dmem_i = 64'h0;
      valid_bus_i  = 1'b1;
      rdata_bus_i  = 64'hBAD;
      for (int i = 0; i < 3; i++) begin
         #1;
         chkb("st.stall_v", valid_bus_o, 1'b1);
         chk("st.stall_a", addr_bus_o, 64'h2000);
         chk("st.stall_wd", wdata_bus_o, 64'hDEADBEEF);
         chkb("st.stall_we", w_en_bus_o, 1'b1);
         chkb("st.stall_br", ready_bus_o, 1'b0);
         tick();
         valid_bus_i = 1'b0;
      end
      ready_bus_i = 1'b1;
      #1;
      chkb("st.rel_v", valid_bus_o, 1'b1);
      tick();
      chkb("st.resp_r", ready_bus_o, 1'b1);
      valid_bus_i = 1'b1;
      rdata_bus_i = 64'h55;
      tick();
      valid_bus_i = 1'b0;
      chkb("st.v_mem", valid_mem_dmem_o, 1'b1);
      chkb("st.v_if", valid_if_o, 1'b0);
      chk("st.rdata", rdata_dmem_o, 64'h55);
      tick();
      chkb("st.end", valid_mem_dmem_o, 1'b0);
      last_mem = 1'b1;

      // both requesters together, four rounds
      valid_imem_i      = 1'b1;
      instr_addr_imem_i = 64'h3000;
      valid_dmem_i      = 1'b1;
      addr_dmem_i       = 64'h4000;
      wdata_dmem_i      = 64'h77;
      w_en_dmem_i       = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic em;
         em = RR ? ~last_mem : 1'b1;
         do_txn($sformatf("both%0d", i), em,
                em ? 64'h4000 : 64'h3000,
                em ? 64'h77 : 64'h0, 1'b0,
                64'h100 + 64'(i));
      end
      valid_imem_i = 1'b0;
      valid_dmem_i = 1'b0;
      wdata_dmem_i = 64'h0;
      tick();

      // IF stalls DELIVER; pending MEM load waits
      valid_imem_i      = 1'b1;
      instr_addr_imem_i = 64'h5000;
      ready_if_i        = 1'b0;
      #1;
      chkb("stl.rdy", ready_imem_o, 1'b1);
      tick();
      valid_imem_i = 1'b0;
      tick();
      valid_bus_i = 1'b1;
      rdata_bus_i = 64'hABCD;
      tick();
      valid_bus_i  = 1'b0;
      valid_dmem_i = 1'b1;
      addr_dmem_i  = 64'h6000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chkb("stl.v_if", valid_if_o, 1'b1);
         chk("stl.d_if", instr_data_if_o, 64'hABCD);
         chkb("stl.rdy_mem", ready_dmem_o, 1'b0);
         tick();
      end
      ready_if_i = 1'b1;
      tick();
      chkb("stl.rel_if", valid_if_o, 1'b0);
      chkb("stl.rel_rdy", ready_dmem_o, 1'b1);
      tick();
      valid_dmem_i = 1'b0;
      chkb("stl.req_v", valid_bus_o, 1'b1);
      chk("stl.req_a", addr_bus_o, 64'h6000);
      tick();
      chkb("rr.in_resp", ready_bus_o, 1'b1);

      // reset pulse while waiting for the response
      rst = 1'b1;
      #1;
      chkb("rr.bus_r", ready_bus_o, 1'b0);
      chkb("rr.bus_v", valid_bus_o, 1'b0);
      chk("rr.addr", addr_bus_o, 64'h0);
      chkb("rr.v_mem", valid_mem_dmem_o, 1'b0);
      valid_bus_i = 1'b1;
      rdata_bus_i = 64'hEEEE;
      tick();
      rst = 1'b0;
      last_mem = 1'b1;
      tick();
      chkb("rr.late_br", ready_bus_o, 1'b0);
      chkb("rr.late_vm", valid_mem_dmem_o, 1'b0);
      tick();
      chk("rr.late_d", rdata_dmem_o, 64'h0);
      valid_bus_i = 1'b0;

      // fetch after reset completes normally
      valid_imem_i      = 1'b1;
      instr_addr_imem_i = 64'h7000;
      do_txn("post", 1'b0, 64'h7000, 64'h0, 1'b0, 64'h93);
      valid_imem_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
